project_select_ctrl: RTL and testbench

- Wishbone-controlled selector that chooses which of the NUM_PROJECTS user designs instantiated in the user project wrapper owns the shared IO, LA and Wishbone resources.
- Sits directly upstream of the instantiated projects. It produces the one-hot select, the per-project resets and the IO isolation signal that the wrapper's gating and mux logic consume.
- Switching between projects is a sequenced handshake: isolate, settle, switch, hold reset, release. This prevents two projects from driving pads at the same time.

---
 rtl/project_select_pkg.sv | 22 ++
 rtl/project_select_wb_regs.sv | 101 ++++++++++
 rtl/project_select_ctrl.sv | 158 +++++++++++++++
 tb/tb_project_select_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_select_pkg.sv
// project_select_pkg: shared constants and types
// for the user project selector.
package project_select_pkg;

  localparam logic [7:0] REG_REQ    = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_SETTLE = 8'h08;

  localparam int ST_VALID = 8;
  localparam int ST_BUSY  = 9;
  localparam int ST_ERR   = 10;

  localparam logic [7:0] ID_NONE = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISOLATE,
    S_SWITCH,
    S_HOLD
  } state_t;

endpackage

// File: rtl/project_select_wb_regs.sv
// project_select_wb_regs: Wishbone slave decode,
// single-cycle ack and the REQ/ERR/SETTLE registers.
module project_select_wb_regs #(
  parameter int          NUM_PROJECTS   = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          SETTLE_DEFAULT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb,
  input  logic        wbs_cyc,
  input  logic        wbs_we,
  input  logic [3:0]  wbs_sel,
  input  logic [31:0] wbs_dat,
  input  logic [31:0] wbs_adr,
  output logic        wbs_ack,
  output logic [31:0] wbs_rdat,
  input  logic [7:0]  active,
  input  logic        valid,
  input  logic        busy,
  output logic [7:0]  req,
  output logic [15:0] settle
);
  import project_select_pkg::*;

  localparam logic [7:0] NP8 = 8'(NUM_PROJECTS);

  logic        hit;
  logic        acc;
  logic        is_req;
  logic        is_status;
  logic        is_settle;
  logic        id_ok;
  logic        err_q;
  logic [31:0] rdata;
  logic        unused_bits;

  assign hit = wbs_stb && wbs_cyc &&
    (wbs_adr[31:8] == BASE_ADDR[31:8]);
  assign acc = hit && !wbs_ack;

  assign is_req    = (wbs_adr[7:0] == REG_REQ);
  assign is_status = (wbs_adr[7:0] == REG_STATUS);
  assign is_settle = (wbs_adr[7:0] == REG_SETTLE);

  assign id_ok = (wbs_dat[7:0] < NP8) ||
    (wbs_dat[7:0] == ID_NONE);

  assign unused_bits = ^{wbs_dat[31:16], wbs_sel[3:2]};

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_req: rdata = {24'h0, req};
      is_status: begin
        rdata[7:0]      = active;
        rdata[ST_VALID] = valid;
        rdata[ST_BUSY]  = busy;
        rdata[ST_ERR]   = err_q;
      end
      is_settle: rdata = {16'h0, settle};
      default: rdata = '0;
    endcase
  end

  // Ack, read data capture and register writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbs_ack  <= 1'b0;
      wbs_rdat <= '0;
      req      <= ID_NONE;
      err_q    <= 1'b0;
      settle   <= 16'(SETTLE_DEFAULT);
    end else begin
      wbs_ack  <= acc;
      wbs_rdat <= (acc && !wbs_we) ? rdata : '0;
      if (acc && wbs_we) begin
        if (is_req && wbs_sel[0]) begin
          if (id_ok) begin
            req <= wbs_dat[7:0];
          end else begin
            err_q <= 1'b1;
          end
        end
        if (is_status && wbs_dat[ST_ERR]) begin
          err_q <= 1'b0;
        end
        if (is_settle) begin
          if (wbs_sel[0]) begin
            settle[7:0] <= wbs_dat[7:0];
          end
          if (wbs_sel[1]) begin
            settle[15:8] <= wbs_dat[15:8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/project_select_ctrl.sv
// project_select_ctrl: picks which user project owns
// the shared pads; isolate, settle, switch, hold, release.
module project_select_ctrl #(
  parameter int          NUM_PROJECTS   = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          SETTLE_DEFAULT = 16,
  parameter int          RST_HOLD       = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] proj_sel,
  output logic [NUM_PROJECTS-1:0] proj_rst_n,
  output logic                    io_isolate,
  output logic                    busy
);
  import project_select_pkg::*;

  localparam logic [15:0] HOLD_LEN =
    (RST_HOLD < 1) ? 16'd1 : 16'(RST_HOLD);

  state_t                  state_q;
  state_t                  state_d;
  logic [15:0]             cnt_q;
  logic [15:0]             cnt_d;
  logic [7:0]              snap_q;
  logic [7:0]              snap_d;
  logic [7:0]              active_q;
  logic [7:0]              active_d;
  logic                    valid_q;
  logic                    valid_d;
  logic [NUM_PROJECTS-1:0] sel_d;
  logic [NUM_PROJECTS-1:0] rst_d;
  logic                    iso_d;
  logic [7:0]              req;
  logic [15:0]             settle;

  function automatic logic [NUM_PROJECTS-1:0] onehot(
    input logic [7:0] id
  );
    onehot = '0;
    for (int i = 0; i < NUM_PROJECTS; i++) begin
      if (id == 8'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  endfunction

  assign busy = (state_q != S_IDLE);

  project_select_wb_regs #(
    .NUM_PROJECTS  (NUM_PROJECTS),
    .BASE_ADDR     (BASE_ADDR),
    .SETTLE_DEFAULT(SETTLE_DEFAULT)
  ) u_regs (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .wbs_stb (wbs_stb_i),
    .wbs_cyc (wbs_cyc_i),
    .wbs_we  (wbs_we_i),
    .wbs_sel (wbs_sel_i),
    .wbs_dat (wbs_dat_i),
    .wbs_adr (wbs_adr_i),
    .wbs_ack (wbs_ack_o),
    .wbs_rdat(wbs_dat_o),
    .active  (active_q),
    .valid   (valid_q),
    .busy    (busy),
    .req     (req),
    .settle  (settle)
  );

  // Next state and next output values of the switch sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    active_d = active_q;
    valid_d  = valid_q;
    sel_d    = proj_sel;
    rst_d    = proj_rst_n;
    iso_d    = io_isolate;
    unique case (state_q)
      S_IDLE: begin
        if ((req != active_q) ||
            ((req != ID_NONE) && !valid_q)) begin
          state_d = S_ISOLATE;
          cnt_d   = (settle == 16'd0) ? 16'd1 : settle;
          snap_d  = req;
          iso_d   = 1'b1;
          rst_d   = '0;
        end
      end
      S_ISOLATE: begin
        if (cnt_q <= 16'd1) begin
          state_d = S_SWITCH;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_SWITCH: begin
        if (snap_q == ID_NONE) begin
          sel_d    = '0;
          valid_d  = 1'b0;
          active_d = ID_NONE;
          state_d  = S_IDLE;
        end else begin
          sel_d    = onehot(snap_q);
          valid_d  = 1'b1;
          active_d = snap_q;
          cnt_d    = HOLD_LEN;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q <= 16'd1) begin
          rst_d   = proj_sel;
          iso_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequence state and registered pad-control outputs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      snap_q     <= ID_NONE;
      active_q   <= '0;
      valid_q    <= 1'b0;
      proj_sel   <= '0;
      proj_rst_n <= '0;
      io_isolate <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      active_q   <= active_d;
      valid_q    <= valid_d;
      proj_sel   <= sel_d;
      proj_rst_n <= rst_d;
      io_isolate <= iso_d;
    end
  end

endmodule

// File: tb/tb_project_select_ctrl.sv
// tb_project_select_ctrl: vectors, directed sequences
// and random traffic against a timeline model.
module tb_project_select_ctrl;

  localparam int          NP      = 8;
  localparam int          HOLD    = 4;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [23:0] BASE_HI = 24'h30_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb   = 1'b0;
  logic        cyc   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = 4'h0;
  logic [31:0] dat   = '0;
  logic [31:0] adr   = '0;

  logic          ack;
  logic [31:0]   rdat;
  logic [NP-1:0] psel;
  logic [NP-1:0] prst;
  logic          iso;
  logic          busy;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  project_select_ctrl #(
    .NUM_PROJECTS  (NP),
    .BASE_ADDR     (BASE),
    .SETTLE_DEFAULT(16),
    .RST_HOLD      (HOLD)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .proj_sel  (psel),
    .proj_rst_n(prst),
    .io_isolate(iso),
    .busy      (busy)
  );

  // Reference model: registers plus a timeline of the
  // current sequence measured in edges since it began.
  logic [7:0]    m_req, m_active, sid;
  logic [15:0]   m_settle;
  logic          m_err, m_valid, m_iso, m_busy, m_ack;
  logic [NP-1:0] m_sel, m_rst;
  logic [31:0]   m_dat, m_rd;
  logic          m_acc;
  int            el, len;

  assign m_acc = stb && cyc &&
    (adr[31:8] == BASE_HI) && !m_ack;

  always_comb begin
    m_rd = '0;
    case (adr[7:0])
      8'h00: m_rd = {24'h0, m_req};
      8'h04: m_rd = {21'h0, m_err, m_busy, m_valid, m_active};
      8'h08: m_rd = {16'h0, m_settle};
      default: m_rd = '0;
    endcase
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_req <= 8'hFF; m_err <= 1'b0; m_settle <= 16'd16;
      m_active <= 8'h00; m_valid <= 1'b0;
      m_sel <= '0; m_rst <= '0; m_iso <= 1'b1;
      m_busy <= 1'b0; m_ack <= 1'b0; m_dat <= '0;
      el <= 0; len <= 1; sid <= 8'hFF;
    end else begin
      m_ack <= m_acc;
      m_dat <= (m_acc && !we) ? m_rd : 32'h0;
      if (m_acc && we) begin
        if (adr[7:0] == 8'h00 && sel[0]) begin
          if (int'(dat[7:0]) < NP || dat[7:0] == 8'hFF)
            m_req <= dat[7:0];
          else
            m_err <= 1'b1;
        end
        if (adr[7:0] == 8'h04 && dat[10]) m_err <= 1'b0;
        if (adr[7:0] == 8'h08) begin
          if (sel[0]) m_settle[7:0] <= dat[7:0];
          if (sel[1]) m_settle[15:8] <= dat[15:8];
        end
      end
      if (!m_busy) begin
        if (m_req != m_active ||
            (m_req != 8'hFF && !m_valid)) begin
          m_busy <= 1'b1; el <= 0; sid <= m_req;
          len <= (m_settle == 16'd0) ? 1 : int'(m_settle);
          m_iso <= 1'b1; m_rst <= '0;
        end
      end else begin
        el <= el + 1;
        if (el + 1 == len + 1) begin
          if (sid == 8'hFF) begin
            m_sel <= '0; m_valid <= 1'b0;
            m_active <= 8'hFF; m_busy <= 1'b0;
          end else begin
            m_sel <= NP'(1) << sid;
            m_active <= sid; m_valid <= 1'b1;
          end
        end else if (sid != 8'hFF &&
                     el + 1 == len + 1 + HOLD) begin
          m_rst <= NP'(1) << sid;
          m_iso <= 1'b0; m_busy <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      check("outputs",
        {13'h0, ack, rdat, psel, prst, iso, busy},
        {13'h0, m_ack, m_dat, m_sel, m_rst, m_iso, m_busy});
      check("rst_invariant",
        64'(($countones(prst) > 1) || (prst != '0 && iso)),
        64'h0);
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      input logic exp_ack,
                      output logic [31:0] rd);
    logic got;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat = d;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; rd = rdat; end
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    check("ack", 64'(got), 64'(exp_ack));
  endtask

  task automatic wait_idle(input int lim);
    int n, quiet;
    n = 0; quiet = 0;
    repeat (2) @(posedge clk);
    while (quiet < 3 && n < lim) begin
      @(posedge clk); #1; n++;
      quiet = busy ? 0 : quiet + 1;
    end
    check("idle_timeout", 64'(quiet >= 3), 64'h1);
  endtask

  task automatic wait_sel(input logic [NP-1:0] v,
                          input int lim, output int n);
    n = 0;
    while (psel !== v && n < lim) begin
      @(posedge clk); #1; n++;
    end
    check("wait_sel", 64'(psel), 64'(v));
  endtask

  task automatic wait_rst(input logic [NP-1:0] v,
                          input int lim, output int n);
    n = 0;
    while (prst !== v && n < lim) begin
      @(posedge clk); #1; n++;
    end
    check("wait_rst", 64'(prst), 64'(v));
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        k;
    logic [31:0] mask;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;
    tbl[0]  = '{1'b1, BASE + 32'h08, 4'hF, 32'h1234, 1'b1, 0, 0};
    tbl[1]  = '{1'b0, BASE + 32'h08, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h1234};
    tbl[2]  = '{1'b1, BASE + 32'h08, 4'h1, 32'hABCD, 1'b1, 0, 0};
    tbl[3]  = '{1'b0, BASE + 32'h08, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h12CD};
    tbl[4]  = '{1'b1, BASE + 32'h08, 4'h2, 32'h5600, 1'b1, 0, 0};
    tbl[5]  = '{1'b0, BASE + 32'h08, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h56CD};
    tbl[6]  = '{1'b1, BASE + 32'h08, 4'hF, 32'h10, 1'b1, 0, 0};
    tbl[7]  = '{1'b0, BASE + 32'h08, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h10};
    tbl[8]  = '{1'b1, BASE + 32'h0C, 4'hF, 32'hFFFF, 1'b1, 0, 0};
    tbl[9]  = '{1'b0, BASE + 32'h0C, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h0};
    tbl[10] = '{1'b0, BASE + 32'h40, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{1'b1, BASE + 32'h100, 4'hF, 32'h3, 1'b0, 0, 0};
    tbl[12] = '{1'b0, BASE, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFF};
    tbl[13] = '{1'b1, BASE, 4'hF, 32'h9, 1'b1, 0, 0};
    tbl[14] = '{1'b0, BASE, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFF};
    tbl[15] = '{1'b0, BASE + 32'h04, 4'hF, 32'h0, 1'b1, 32'h400, 32'h400};
    tbl[16] = '{1'b1, BASE, 4'hE, 32'h3, 1'b1, 0, 0};
    tbl[17] = '{1'b0, BASE, 4'hF, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFF};
    tbl[18] = '{1'b1, BASE + 32'h04, 4'hF, 32'h400, 1'b1, 0, 0};
    tbl[19] = '{1'b0, BASE + 32'h04, 4'hF, 32'h0, 1'b1, 32'h7FF, 32'h0FF};

    @(posedge clk);
    mon_on = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    xfer(1'b0, BASE + 32'h04, 4'hF, 0, 1'b1, rd);
    check("reset_status", 64'(rd), 64'h0);
    check("reset_rst", 64'(prst), 64'h0);
    check("reset_iso", 64'(iso), 64'h1);
    wait_idle(100);

    for (int i = 0; i < 20; i++) begin
      xfer(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, tbl[i].k, rd);
      if (!tbl[i].w && tbl[i].k)
        check($sformatf("vec%0d", i),
              64'(rd & tbl[i].mask), 64'(tbl[i].exp));
    end
    wait_idle(100);

    xfer(1'b1, BASE, 4'hF, 32'h3, 1'b1, rd);
    check("busy_before", 64'(busy), 64'h0);
    @(posedge clk); #1;
    check("busy_rise", 64'(busy), 64'h1);
    wait_sel(8'h08, 40, n);
    check("settle_len", 64'(n), 64'd17);
    wait_rst(8'h08, 20, n);
    check("hold_len", 64'(n), 64'd4);
    check("iso_release", 64'(iso), 64'h0);
    xfer(1'b0, BASE + 32'h04, 4'hF, 0, 1'b1, rd);
    check("status_p3", 64'(rd), 64'h103);

    xfer(1'b1, BASE, 4'hF, 32'h5, 1'b1, rd);
    repeat (6) @(posedge clk);
    xfer(1'b1, BASE, 4'hF, 32'h6, 1'b1, rd);
    wait_rst(8'h20, 80, n);
    wait_rst(8'h40, 80, n);
    wait_idle(100);
    check("final_sel6", 64'(psel), 64'h40);

    xfer(1'b1, BASE, 4'hF, 32'h2, 1'b1, rd);
    wait_rst(8'h04, 80, n);
    xfer(1'b1, BASE, 4'hF, 32'hFF, 1'b1, rd);
    wait_idle(100);
    check("desel_sel", 64'(psel), 64'h0);
    check("desel_rst", 64'(prst), 64'h0);
    check("desel_iso", 64'(iso), 64'h1);
    xfer(1'b0, BASE + 32'h04, 4'hF, 0, 1'b1, rd);
    check("status_none", 64'(rd), 64'h0FF);

    xfer(1'b1, BASE + 32'h08, 4'hF, 32'h0, 1'b1, rd);
    xfer(1'b1, BASE, 4'hF, 32'h1, 1'b1, rd);
    @(posedge clk); #1;
    check("busy_rise1", 64'(busy), 64'h1);
    wait_sel(8'h02, 10, n);
    check("settle_zero", 64'(n), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset",
      {38'h0, psel, prst, iso, busy, ack, rdat == 32'h0},
      {38'h0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(100);
    xfer(1'b0, BASE + 32'h08, 4'hF, 0, 1'b1, rd);
    check("settle_reset", 64'(rd), 64'h10);

    for (int k = 0; k < 40; k++) begin
      int r, p;
      logic [7:0] id;
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        p = $urandom_range(0, 11);
        if (p < NP) id = 8'(p);
        else if (p == NP) id = 8'hFF;
        else id = 8'(NP + $urandom_range(0, 20));
        xfer(1'b1, BASE, 4'hF, {24'h0, id}, 1'b1, rd);
      end else if (r == 5) begin
        xfer(1'b1, BASE + 32'h08, 4'h3,
             32'($urandom_range(0, 5)), 1'b1, rd);
      end else if (r == 6) begin
        xfer($urandom_range(0, 1) == 1, BASE + 32'h04, 4'hF,
             32'h400, 1'b1, rd);
      end else if (r == 7) begin
        xfer(1'b0, BASE, 4'hF, 0, 1'b1, rd);
      end else if (r == 8) begin
        xfer(1'b1, BASE + 32'h100 * $urandom_range(1, 3),
             4'hF, 32'h1, 1'b0, rd);
      end else begin
        xfer(1'b0, BASE + 32'h20, 4'hF, 0, 1'b1, rd);
      end
      repeat ($urandom_range(0, 12)) @(posedge clk);
    end
    wait_idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
